// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: IF/ID bundle, FSM states, constants.
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{
        instr:    NOP_INSTR,
        pc:       32'h0,
        pc_plus4: 32'h0,
        valid:    1'b0
    };

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load, hold and flush.
module if_id_register
    import fetch_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    if_id_t r_q;

    // Flush keeps the PC fields so the bubble still carries a location.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q <= IF_ID_RESET;
        end else if (i_flush) begin
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (i_load) begin
            r_q.instr    <= i_instr;
            r_q.pc       <= i_pc;
            r_q.pc_plus4 <= i_pc_plus4;
            r_q.valid    <= 1'b1;
        end
    end

    assign o_instr    = r_q.instr;
    assign o_pc       = r_q.pc;
    assign o_pc_plus4 = r_q.pc_plus4;
    assign o_valid    = r_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-address mux, BOOT/RUN FSM, fetch counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 28
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic [31:0] Instruction_Fetch,
    output logic [31:0] Pc_Out,
    output logic [31:0] IfId_Instr,
    output logic [31:0] IfId_Pc,
    output logic [31:0] IfId_Pc_Plus4,
    output logic        IfId_Valid,
    output logic        Misaligned_Fault,
    output logic [15:0] Fetch_Count
);

    localparam logic [31:0] LP_IMEM = 32'(IMEM_BYTES);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_pc_plus4;
    logic         r_fault;
    logic         w_fault_nxt;
    logic [15:0]  r_count;
    logic         w_load;
    logic         w_flush;
    logic         w_tgt_ok;

    assign w_pc_plus4 = r_pc + INSTR_BYTES;
    assign w_tgt_ok   = (Branch_Target[1:0] == 2'b00)
                     && (Branch_Target < LP_IMEM);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_fault_nxt = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (Branch_Taken) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_tgt_ok ? Branch_Target : RESET_PC;
                    w_fault_nxt = ~w_tgt_ok;
                end else if (!Stall) begin
                    w_load   = 1'b1;
                    w_pc_nxt = (w_pc_plus4 >= LP_IMEM) ? RESET_PC
                                                       : w_pc_plus4;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= 16'h0;
        end else if (w_load && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'h1;
        end
    end

    if_id_register u_if_id (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_instr    (Instruction_Fetch),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (IfId_Instr),
        .o_pc       (IfId_Pc),
        .o_pc_plus4 (IfId_Pc_Plus4),
        .o_valid    (IfId_Valid)
    );

    assign Pc_Out           = r_pc;
    assign Misaligned_Fault = r_fault;
    assign Fetch_Count      = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 28-byte big-endian memory model.
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] Instruction_Fetch;
    logic [31:0] Pc_Out;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_Pc;
    logic [31:0] IfId_Pc_Plus4;
    logic        IfId_Valid;
    logic        Misaligned_Fault;
    logic [15:0] Fetch_Count;

    int total = 0;
    int bad   = 0;

    fetch_stage #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (28)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Stall             (Stall),
        .Branch_Taken      (Branch_Taken),
        .Branch_Target     (Branch_Target),
        .Instruction_Fetch (Instruction_Fetch),
        .Pc_Out            (Pc_Out),
        .IfId_Instr        (IfId_Instr),
        .IfId_Pc           (IfId_Pc),
        .IfId_Pc_Plus4     (IfId_Pc_Plus4),
        .IfId_Valid        (IfId_Valid),
        .Misaligned_Fault  (Misaligned_Fault),
        .Fetch_Count       (Fetch_Count)
    );

    always #5 Clk = ~Clk;

    // Byte k of memory holds k+8'h10, read big-endian.
    logic [7:0] mem [0:27];
    initial begin
        for (int k = 0; k < 28; k++) mem[k] = 8'(k + 16);
    end

    always_comb begin
        Instruction_Fetch = 32'h0;
        if (Pc_Out < 32'd25)
            Instruction_Fetch = {mem[Pc_Out[4:0]],
                                 mem[Pc_Out[4:0] + 5'd1],
                                 mem[Pc_Out[4:0] + 5'd2],
                                 mem[Pc_Out[4:0] + 5'd3]};
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic [31:0] p4;
        logic        valid;
        logic        fault;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt [22];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " pc"},    Pc_Out,                  v.pc);
        chk({tag, " instr"}, IfId_Instr,              v.instr);
        chk({tag, " ifpc"},  IfId_Pc,                 v.ifpc);
        chk({tag, " p4"},    IfId_Pc_Plus4,           v.p4);
        chk({tag, " valid"}, {31'h0, IfId_Valid},     {31'h0, v.valid});
        chk({tag, " fault"}, {31'h0, Misaligned_Fault}, {31'h0, v.fault});
        chk({tag, " cnt"},   {16'h0, Fetch_Count},    {16'h0, v.cnt});
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(logic s, logic b, logic [31:0] t,
                                logic [31:0] pc, logic [31:0] ins,
                                logic [31:0] ip, logic [31:0] p4,
                                logic v, logic f, logic [15:0] c);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t;
        r.pc = pc; r.instr = ins; r.ifpc = ip; r.p4 = p4;
        r.valid = v; r.fault = f; r.cnt = c;
        return r;
    endfunction

    vec_t rst_v;
    logic [31:0] exp_pc;

    initial begin
        // row 0 is the BOOT cycle: a bad branch request must be ignored
        vt[0]  = mk(0,1,32'h6,  0,  32'h13,       0, 0, 0,0,0);
        vt[1]  = mk(0,0,0,      4,  32'h10111213, 0, 4, 1,0,1);
        vt[2]  = mk(0,0,0,      8,  32'h14151617, 4, 8, 1,0,2);
        vt[3]  = mk(1,0,0,      8,  32'h14151617, 4, 8, 1,0,2);
        vt[4]  = mk(1,0,0,      8,  32'h14151617, 4, 8, 1,0,2);
        vt[5]  = mk(1,0,0,      8,  32'h14151617, 4, 8, 1,0,2);
        vt[6]  = mk(0,0,0,      12, 32'h18191A1B, 8, 12,1,0,3);
        vt[7]  = mk(0,0,0,      16, 32'h1C1D1E1F, 12,16,1,0,4);
        vt[8]  = mk(0,0,0,      20, 32'h20212223, 16,20,1,0,5);
        vt[9]  = mk(0,1,32'd16, 16, 32'h13,       16,20,0,0,5);
        vt[10] = mk(0,0,0,      20, 32'h20212223, 16,20,1,0,6);
        vt[11] = mk(0,0,0,      24, 32'h24252627, 20,24,1,0,7);
        vt[12] = mk(0,0,0,      0,  32'h28292A2B, 24,28,1,0,8);
        vt[13] = mk(1,1,32'd4,  4,  32'h13,       24,28,0,0,8);
        vt[14] = mk(0,1,32'h6,  0,  32'h13,       24,28,0,1,8);
        vt[15] = mk(0,0,0,      4,  32'h10111213, 0, 4, 1,0,9);
        vt[16] = mk(0,1,32'h40, 0,  32'h13,       0, 4, 0,1,9);
        vt[17] = mk(0,0,0,      4,  32'h10111213, 0, 4, 1,0,10);
        vt[18] = mk(0,0,0,      8,  32'h14151617, 4, 8, 1,0,11);
        vt[19] = mk(0,0,0,      12, 32'h18191A1B, 8, 12,1,0,12);
        vt[20] = mk(0,0,0,      16, 32'h1C1D1E1F, 12,16,1,0,13);
        vt[21] = mk(0,0,0,      20, 32'h20212223, 16,20,1,0,14);
        rst_v  = mk(0,0,0,      0,  32'h13,       0, 0, 0,0,0);

        Reset = 1'b1;
        Stall = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Target = 32'h0;
        tick();
        tick();
        chk_all("reset", rst_v);
        Reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            Stall         = vt[i].stall;
            Branch_Taken  = vt[i].br;
            Branch_Target = vt[i].tgt;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i]);
        end
        Stall = 1'b0;
        Branch_Taken = 1'b0;
        Branch_Target = 32'h0;

        // asynchronous reset mid-run, no clock edge in between
        Reset = 1'b1;
        #1;
        chk_all("async_rst", rst_v);
        tick();
        Reset = 1'b0;
        tick();
        chk_all("reboot", rst_v);

        // one full lap after reset
        exp_pc = 32'h0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("lap%0d ifpc", i), IfId_Pc, exp_pc);
            exp_pc = (exp_pc + 4 >= 28) ? 32'h0 : exp_pc + 4;
            chk($sformatf("lap%0d pc", i), Pc_Out, exp_pc);
        end
        chk("lap cnt", {16'h0, Fetch_Count}, 32'd7);

        for (int i = 0; i < 65527; i++) tick();
        chk("cnt pre-sat", {16'h0, Fetch_Count}, 32'hFFFE);
        tick();
        chk("cnt sat", {16'h0, Fetch_Count}, 32'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt stick", {16'h0, Fetch_Count}, 32'hFFFF);
        chk("sat valid", {31'h0, IfId_Valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
